// File: rtl/key_event_ctrl.sv
// key_event_ctrl: shared debounce sample tick, per-key pending latches and a
// round-robin arbiter that turns key presses into a valid/ready code stream.

// One pending-request latch per key.
module key_pend_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic set,   // qualified press pulse for this key
  input  logic gnt,   // arbiter grants this key this cycle
  output logic pend,
  output logic lost   // press arrived while a request was already waiting
);
  logic pend_q, pend_d;

  // A press on the grant cycle wins over the clear, so that press is kept and
  // becomes a second event instead of being counted as lost.
  always_comb begin
    pend_d = set | (pend_q & ~gnt);
    lost   = set & pend_q & ~gnt;
  end

  // Pending flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;
endmodule

module key_event_ctrl #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 2,
  parameter int TICK_DIV = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] key_pulse,
  output logic                sample_tick,
  output logic                evt_valid,
  output logic [CODE_W-1:0]   evt_code,
  input  logic                evt_ready,
  output logic [NUM_KEYS-1:0] pend,
  output logic                overflow,
  input  logic                clr_overflow
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sample_tick_q, sample_tick_d;
  logic                  evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0]     evt_code_q, evt_code_d;
  logic [CODE_W-1:0]     rr_q, rr_d;
  logic                  overflow_q, overflow_d;
  logic [NUM_KEYS-1:0]   pend_q, lost_vec, gnt_oh, set_vec;
  logic [2*NUM_KEYS-1:0] dbl;
  logic [NUM_KEYS-1:0]   rot;
  logic                  slot_free, gnt_vld;
  logic [CODE_W-1:0]     gnt_idx;
  int                    off, g, n;

  assign set_vec = en ? key_pulse : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
      key_pend_lane u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .set  (set_vec[gi]),
        .gnt  (gnt_oh[gi]),
        .pend (pend_q[gi]),
        .lost (lost_vec[gi])
      );
    end
  endgenerate

  // Tick divider: counts only while enabled, strobe follows the terminal count.
  always_comb begin
    cnt_d         = cnt_q;
    sample_tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
        cnt_d         = '0;
        sample_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Round-robin pick: rotate pend so the pointer sits at bit 0, take the
  // lowest set bit, then rotate the offset back to a key index.
  always_comb begin
    slot_free = ~evt_valid_q | evt_ready;
    dbl       = {pend_q, pend_q} >> rr_q;
    rot       = dbl[NUM_KEYS-1:0];
    gnt_vld   = 1'b0;
    off       = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!gnt_vld && rot[k]) begin
        gnt_vld = 1'b1;
        off     = k;
      end
    end
    gnt_vld = gnt_vld & slot_free;
    g = int'(rr_q) + off;
    if (g >= NUM_KEYS) g = g - NUM_KEYS;
    gnt_idx = g[CODE_W-1:0];
    n = g + 1;
    if (n == NUM_KEYS) n = 0;
    for (int i = 0; i < NUM_KEYS; i++) gnt_oh[i] = gnt_vld && (i == g);
  end

  // Output slot, pointer and sticky overflow next-state.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    rr_d        = rr_q;
    if (gnt_vld) begin
      evt_valid_d = 1'b1;
      evt_code_d  = gnt_idx;
      rr_d        = n[CODE_W-1:0];
    end else if (slot_free) begin
      evt_valid_d = 1'b0;
    end
    overflow_d = (overflow_q & ~clr_overflow) | (|lost_vec);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      sample_tick_q <= 1'b0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      rr_q          <= '0;
      overflow_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sample_tick_q <= sample_tick_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      rr_q          <= rr_d;
      overflow_q    <= overflow_d;
    end
  end

  assign sample_tick = sample_tick_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign pend        = pend_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios with literal expectations plus
// a randomized run, all outputs compared every cycle against a behavioural model.
module tb_key_event_ctrl;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  key_pulse = '0;
  logic          evt_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          sample_tick, evt_valid, overflow;
  logic [CW-1:0] evt_code;
  logic [N-1:0]  pend;

  int tests = 0;
  int fails = 0;

  key_event_ctrl #(.NUM_KEYS(N), .CODE_W(CW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .key_pulse(key_pulse),
    .sample_tick(sample_tick), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(evt_ready), .pend(pend), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set per key, nearest pending key at or above
  // the pointer wins, tick every TD-th enabled cycle.
  logic [N-1:0] m_pend = '0;
  int           m_rr = 0;
  logic         m_valid = 1'b0;
  int           m_code = 0;
  logic         m_ovf = 1'b0;
  int           m_en_cnt = 0;
  logic         m_tick = 1'b0;

  task automatic model_step();
    logic free, lost;
    int g, best, d;
    logic [N-1:0] np;
    free = !m_valid || evt_ready;
    g = -1;
    best = N;
    if (free) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          d = (i - m_rr + N) % N;
          if (d < best) begin best = d; g = i; end
        end
      end
    end
    lost = 1'b0;
    np = m_pend;
    for (int i = 0; i < N; i++) begin
      if (i == g) np[i] = 1'b0;
      if (en && key_pulse[i]) begin
        if (m_pend[i] && i != g) lost = 1'b1;
        np[i] = 1'b1;
      end
    end
    m_pend = np;
    m_ovf = lost || (m_ovf && !clr_overflow);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_code  = g;
      m_rr    = (g + 1) % N;
    end else if (free) begin
      m_valid = 1'b0;
    end
    m_tick = en && (m_en_cnt % TD == TD - 1);
    if (en) m_en_cnt++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_rr = 0; m_valid = 1'b0; m_code = 0;
      m_ovf = 1'b0; m_en_cnt = 0; m_tick = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_tick", sample_tick, m_tick);
      chk("m_valid", evt_valid, m_valid);
      chk("m_code", evt_code, m_code);
      chk("m_pend", pend, m_pend);
      chk("m_ovf", overflow, m_ovf);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    key_pulse = v;
    @(negedge clk);
    key_pulse = '0;
  endtask

  task automatic chk_evt(input string name, input logic v, input int code);
    chk({name, "_valid"}, evt_valid, v);
    if (v) chk({name, "_code"}, evt_code, code);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_valid", evt_valid, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_code", evt_code, 0);

    // 1: tick on edges 8 and 21 (en low on edges 10..14, count held)
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      en = !(e >= 10 && e <= 14);
      cyc();
      chk("t1_tick", sample_tick, (e == 8 || e == 21) ? 1 : 0);
    end
    en = 1'b1;

    // 2: single press on key 2
    pulse(4'b0100);
    chk("t2_pend", pend, 4'b0100);
    chk("t2_valid0", evt_valid, 0);
    cyc();
    chk_evt("t2_evt", 1, 2);
    chk("t2_pend_clr", pend, 0);
    cyc();
    chk("t2_idle", evt_valid, 0);

    // 3: bring pointer to 0, then 1011 -> 0,1,3 and 1001 -> 0,3
    pulse(4'b1000);
    cyc(); chk_evt("t3_k3", 1, 3);
    cyc(); chk("t3_idle0", evt_valid, 0);
    pulse(4'b1011);
    cyc(); chk_evt("t3_a0", 1, 0);
    cyc(); chk_evt("t3_a1", 1, 1);
    cyc(); chk_evt("t3_a3", 1, 3);
    cyc(); chk("t3_idle1", evt_valid, 0);
    pulse(4'b1001);
    cyc(); chk_evt("t3_b0", 1, 0);
    cyc(); chk_evt("t3_b3", 1, 3);
    cyc(); chk("t3_idle2", evt_valid, 0);

    // 4: backpressure and overflow
    evt_ready = 1'b0;
    pulse(4'b0010);
    cyc(); chk_evt("t4_first", 1, 1);
    pulse(4'b0010);
    chk("t4_pend", pend, 4'b0010);
    chk("t4_ovf0", overflow, 0);
    chk_evt("t4_hold", 1, 1);
    pulse(4'b0010);
    chk("t4_ovf1", overflow, 1);
    chk("t4_pend2", pend, 4'b0010);
    evt_ready = 1'b1;
    cyc(); chk_evt("t4_second", 1, 1);
    chk("t4_pend_clr", pend, 0);
    cyc(); chk("t4_idle", evt_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // 5: press lands on the grant cycle of the same key
    pulse(4'b0001);
    chk("t5_pend", pend, 4'b0001);
    pulse(4'b0001);
    chk_evt("t5_e1", 1, 0);
    chk("t5_pend_kept", pend, 4'b0001);
    chk("t5_no_ovf", overflow, 0);
    cyc(); chk_evt("t5_e2", 1, 0);
    chk("t5_pend_clr", pend, 0);
    cyc(); chk("t5_idle", evt_valid, 0);

    // 6: asynchronous reset mid-operation
    evt_ready = 1'b0;
    pulse(4'b0001);
    cyc(); chk_evt("t6_pre", 1, 0);
    pulse(4'b0110);
    chk("t6_pend", pend, 4'b0110);
    chk("t6_valid", evt_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_pend", pend, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_tick", sample_tick, 0);
    cyc();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk("t6_no_evt", evt_valid, 0);
      chk("t6_tick", sample_tick, (e == 8) ? 1 : 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      key_pulse    = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      en           = ($urandom_range(0, 9) != 0);
      evt_ready    = ($urandom_range(0, 2) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      cyc();
    end
    key_pulse = '0;
    clr_overflow = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Central controller for a bank of key debouncers.
- Generates one shared debounce sample tick for all debouncer instances, so each instance no longer needs its own free-running counter.
- Latches each debouncer's one-cycle press pulse as a pending request.
- Round-robin arbitrates pending presses into a single key-code event stream with a valid/ready handshake toward the user-logic consumer (menu FSM, display control).

Parameters:
- NUM_KEYS, 4, number of debounced key inputs (2..16).
- CODE_W, 2, event code width; must satisfy 2**CODE_W >= NUM_KEYS.
- TICK_DIV, 4096, sample tick period in clk cycles (>= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  1 = tick running and new presses accepted; 0 = tick halted and key_pulse ignored.
- key_pulse  in  NUM_KEYS  one-cycle press pulses from the debouncers; bit i = key i.
- sample_tick  out  1  one-cycle strobe every TICK_DIV cycles, fanned out to the debouncers.
- evt_valid  out  1  event available.
- evt_code  out  CODE_W  index of the pressed key; valid while evt_valid = 1.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- pend  out  NUM_KEYS  registered pending-request vector (status/debug).
- overflow  out  1  sticky: a press was lost.
- clr_overflow  in  1  one-cycle clear of overflow.

Behaviour:
- Reset (async, rst_n = 0): tick counter = 0, sample_tick = 0, pend = 0, evt_valid = 0, evt_code = 0, overflow = 0, rr pointer = 0. All outputs are registered.
- Tick counter:
  - Counts 0..TICK_DIV-1 while en = 1 and wraps to 0.
  - sample_tick = 1 for exactly the cycle after the counter reaches TICK_DIV-1. With TICK_DIV = 8 after reset, it is high on clock edges 8, 16, 24, ...
  - en = 0: counter holds its value and sample_tick = 0.
- Pending set:
  - If en = 1 and key_pulse[i] = 1, pend[i] is 1 next cycle.
  - Pulse on key i while pend[i] = 1 and key i is not granted that cycle: the press is lost, overflow is 1 next cycle, and pend[i] stays 1.
- Pending clear: pend[i] is cleared when key i is granted.
  - Same-cycle grant and pulse on key i: set wins. pend[i] stays 1, no overflow, and the key produces a second event later.
- Output slot free: evt_valid = 0, or evt_valid & evt_ready this cycle.
- Grant:
  - When the slot is free and the registered pend is nonzero, select the first set bit of pend searching upward from rr pointer, with wrap from NUM_KEYS-1 to 0.
  - Next cycle: evt_valid = 1, evt_code = grant index, rr pointer = (grant + 1) mod NUM_KEYS.
  - Arbitration uses registered pend only; a pulse in the current cycle is not eligible until the next cycle.
- No grant while the slot is free: evt_valid goes to 0, and evt_code holds its last value.
- Latency: pulse sampled at edge t → pend at t+1 → evt_valid/evt_code at t+2, provided the slot is free.
- Throughput: with evt_ready held at 1, one event per cycle (back-to-back, no bubble).
- Handshake:
  - While evt_valid = 1 and evt_ready = 0, evt_valid and evt_code are held stable.
  - evt_valid never drops without acceptance, except on reset.
- Overflow:
  - Set by a lost press; cleared by clr_overflow.
  - Simultaneous set and clear: set wins.
- en = 0: pending requests still drain through the arbiter and handshake; only new pulses and the tick are suppressed.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously). In-flight events are discarded and not replayed.

Test Plan:
1. TICK_DIV = 8, en = 1 after reset: sample_tick high exactly on edges 8, 16, 24. en = 0 at edge 10: no tick until en returns, then the count resumes from the held value.
2. key_pulse = 4'b0100 at edge t, evt_ready = 1: pend[2] = 1 at t+1; evt_valid = 1 with evt_code = 2 at t+2 for one cycle; pend = 0 after.
3. key_pulse = 4'b1011 in one cycle, evt_ready = 1, rr = 0: codes 0, 1, 3 on consecutive cycles. Then pulses 4'b1001: rr = 0 after the wrap, so codes 0 then 3.
4. Backpressure, evt_ready = 0:
   - Pulse key 1 → evt_code = 1 held.
   - Pulse key 1 again → pend[1] = 1.
   - Third pulse on key 1 → overflow = 1.
   - evt_ready = 1 → two events with code 1, then evt_valid = 0.
   - clr_overflow → overflow = 0.
5. Pulse key 0 in the exact cycle pend[0] is granted: no overflow; two events with code 0 are produced.
6. rst_n low while evt_valid = 1 and pend = 4'b0110: evt_valid, pend, overflow and the counter read 0 before the next clk edge. No events after release until new pulses arrive.
